cache_refill_controller: RTL and testbench

- Miss-handling sequencer for the set-associative cache.
- On a miss it samples the replacement-way selection, writes back the victim if it is dirty, fetches the missing line from memory, and writes it into the chosen way with one fill pulse.
- Sits between the cache lookup stage, the way-replacement logic, the tag/data arrays and the lower-level memory port.
- Handles one miss at a time.

---
 rtl/cache_refill_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_cache_refill_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_controller.sv
// ----------------------------------------------------------------------------
// cache_refill_controller
//
// Miss-handling sequencer for the set-associative cache. One miss is handled
// at a time. On acceptance the victim way is chosen from the replacement
// logic's vector, and the victim line and the miss address are captured. If
// the victim is valid and dirty, it is written back first. Then the missing
// line is read from memory and written into the victim way with a single
// fill strobe.
//
// Ports
//   clk             : clock, all state updates on the rising edge
//   rst             : asynchronous reset, active low
//   miss_valid      : miss request from the lookup stage
//   miss_ready      : controller idle and able to accept a miss
//   miss_addr       : line address of the miss
//   valid_ways      : valid bits of the indexed set
//   dirty_ways      : dirty bits of the indexed set
//   repl_way        : one-hot way chosen by the replacement logic
//   victim_addr     : line address of the way selected by victim_way (array read)
//   victim_data     : line data of the way selected by victim_way (array read)
//   victim_way      : one-hot victim way driven to the arrays
//   mem_req_valid   : memory request valid
//   mem_req_ready   : memory accepts the request
//   mem_req_write   : 1 = writeback, 0 = line read
//   mem_req_addr    : request line address
//   mem_req_wdata   : writeback line data
//   mem_resp_valid  : write acknowledge or read data valid
//   mem_resp_data   : read line data
//   fill_en         : one-cycle array write strobe
//   fill_way        : way being filled (same as victim_way)
//   fill_addr       : line address being filled
//   fill_data       : line data being filled
//   done            : one-cycle pulse when the miss completes
//   busy            : high whenever the controller is not idle
//   miss_cnt        : saturating count of accepted misses
//   wb_cnt          : saturating count of completed writebacks
// ----------------------------------------------------------------------------
module cache_refill_controller #(
    parameter int WAYS       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic [WAYS-1:0]       valid_ways,
    input  logic [WAYS-1:0]       dirty_ways,
    input  logic [WAYS-1:0]       repl_way,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [LINE_WIDTH-1:0] victim_data,
    output logic [WAYS-1:0]       victim_way,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_resp_valid,
    input  logic [LINE_WIDTH-1:0] mem_resp_data,
    output logic                  fill_en,
    output logic [WAYS-1:0]       fill_way,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  miss_cnt,
    output logic [CNT_WIDTH-1:0]  wb_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FILL    = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic [WAYS-1:0]       victim_way_q;
    logic [ADDR_WIDTH-1:0] victim_addr_q;
    logic [LINE_WIDTH-1:0] victim_data_q;
    logic [LINE_WIDTH-1:0] rd_data_q;
    logic [CNT_WIDTH-1:0]  miss_cnt_q;
    logic [CNT_WIDTH-1:0]  wb_cnt_q;

    logic [WAYS-1:0]       sel_way;
    logic                  wb_needed;
    logic                  accept;
    logic                  wb_ack;
    logic                  rd_ack;

    // Lowest set bit of the replacement vector; a proper one-hot vector maps
    // to itself, and an empty vector falls back to way 0.
    function automatic logic [WAYS-1:0] pick_way(input logic [WAYS-1:0] req);
        logic [WAYS-1:0] sel;
        logic            found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (req[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!found) begin
            sel[0] = 1'b1;
        end
        return sel;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign sel_way   = pick_way(repl_way);
    assign wb_needed = |(valid_ways & dirty_ways & sel_way);
    assign accept    = (state == IDLE) && miss_valid;
    assign wb_ack    = (state == WB_WAIT) && mem_resp_valid;
    assign rd_ack    = (state == RD_WAIT) && mem_resp_valid;

    // While a miss is being offered the arrays must already be addressed with
    // the way that is about to be latched, so that victim_addr/victim_data
    // captured in the acceptance cycle belong to the chosen victim.
    assign victim_way = accept ? sel_way : victim_way_q;

    assign mem_req_addr  = (state == WB_REQ) ? victim_addr_q : miss_addr_q;
    assign mem_req_wdata = victim_data_q;
    assign fill_way      = victim_way_q;
    assign fill_addr     = miss_addr_q;
    assign fill_data     = rd_data_q;
    assign miss_cnt      = miss_cnt_q;
    assign wb_cnt        = wb_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        miss_ready    = 1'b0;
        busy          = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        fill_en       = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                busy       = 1'b0;
                if (miss_valid) begin
                    state_nxt = wb_needed ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = WB_WAIT;
                end
            end
            WB_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                fill_en   = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Miss context captured at acceptance, read data captured at response;
    // fill outputs come only from these registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_addr_q   <= '0;
            victim_way_q  <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            rd_data_q     <= '0;
            miss_cnt_q    <= '0;
            wb_cnt_q      <= '0;
        end else begin
            if (accept) begin
                miss_addr_q   <= miss_addr;
                victim_way_q  <= sel_way;
                victim_addr_q <= victim_addr;
                victim_data_q <= victim_data;
                miss_cnt_q    <= sat_inc(miss_cnt_q);
            end
            if (wb_ack) begin
                wb_cnt_q <= sat_inc(wb_cnt_q);
            end
            if (rd_ack) begin
                rd_data_q <= mem_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_controller.sv
// ----------------------------------------------------------------------------
// tb_cache_refill_controller
//
// Drives misses into the refill controller while acting as the tag/data
// arrays and the memory port. Expected behaviour comes from a transaction
// level model: victim choice by lowest set bit, writeback decided from the
// valid/dirty bits, request/response ordering, and saturating counters.
// A second instance with 2-bit counters shares all inputs.
// ----------------------------------------------------------------------------
module tb_cache_refill_controller;

    localparam int WAYS = 4;
    localparam int AW   = 32;
    localparam int LW   = 128;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miss_valid = 1'b0;
    logic          miss_ready;
    logic [AW-1:0] miss_addr = '0;
    logic [3:0]    valid_ways = '0;
    logic [3:0]    dirty_ways = '0;
    logic [3:0]    repl_way = '0;
    logic [AW-1:0] victim_addr;
    logic [LW-1:0] victim_data;
    logic [3:0]    victim_way;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_req_write;
    logic [AW-1:0] mem_req_addr;
    logic [LW-1:0] mem_req_wdata;
    logic          mem_resp_valid = 1'b0;
    logic [LW-1:0] mem_resp_data = '0;
    logic          fill_en;
    logic [3:0]    fill_way;
    logic [AW-1:0] fill_addr;
    logic [LW-1:0] fill_data;
    logic          done;
    logic          busy;
    logic [CW-1:0] miss_cnt;
    logic [CW-1:0] wb_cnt;

    // Outputs of the small-counter instance
    logic          s_miss_ready, s_mem_req_valid, s_mem_req_write, s_fill_en, s_done, s_busy;
    logic [3:0]    s_victim_way, s_fill_way;
    logic [AW-1:0] s_mem_req_addr, s_fill_addr;
    logic [LW-1:0] s_mem_req_wdata, s_fill_data;
    logic [1:0]    s_miss_cnt, s_wb_cnt;

    // Array model: combinational read addressed by victim_way
    logic [AW-1:0] arr_addr [WAYS];
    logic [LW-1:0] arr_data [WAYS];
    logic [1:0]    vidx;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_miss = 0;
    int exp_wb   = 0;

    always #5 clk = ~clk;

    always_comb begin
        vidx = 2'd0;
        for (int i = 0; i < WAYS; i++) begin
            if (victim_way[i]) vidx = 2'(i);
        end
    end
    assign victim_addr = arr_addr[vidx];
    assign victim_data = arr_data[vidx];

    cache_refill_controller #(.WAYS(WAYS), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .valid_ways(valid_ways), .dirty_ways(dirty_ways), .repl_way(repl_way),
        .victim_addr(victim_addr), .victim_data(victim_data), .victim_way(victim_way),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_en(fill_en), .fill_way(fill_way), .fill_addr(fill_addr), .fill_data(fill_data),
        .done(done), .busy(busy), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    cache_refill_controller #(.WAYS(WAYS), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(s_miss_ready), .miss_addr(miss_addr),
        .valid_ways(valid_ways), .dirty_ways(dirty_ways), .repl_way(repl_way),
        .victim_addr(victim_addr), .victim_data(victim_data), .victim_way(s_victim_way),
        .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(s_mem_req_write), .mem_req_addr(s_mem_req_addr), .mem_req_wdata(s_mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .fill_en(s_fill_en), .fill_way(s_fill_way), .fill_addr(s_fill_addr), .fill_data(s_fill_data),
        .done(s_done), .busy(s_busy), .miss_cnt(s_miss_cnt), .wb_cnt(s_wb_cnt)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Victim rule: lowest set bit of repl_way, way 0 if none set
    function automatic int way_index(input logic [3:0] r);
        for (int i = 0; i < WAYS; i++) begin
            if (r[i]) return i;
        end
        return 0;
    endfunction

    task automatic fill_arrays();
        for (int i = 0; i < WAYS; i++) begin
            arr_addr[i] = $urandom;
            arr_data[i] = rand_line();
        end
    endtask

    task automatic check_counters();
        chk("miss_cnt", LW'(miss_cnt), LW'(sat(exp_miss, 65535)));
        chk("wb_cnt", LW'(wb_cnt), LW'(sat(exp_wb, 65535)));
        chk("sat_miss_cnt", LW'(s_miss_cnt), LW'(sat(exp_miss, 3)));
        chk("sat_wb_cnt", LW'(s_wb_cnt), LW'(sat(exp_wb, 3)));
    endtask

    // Memory side of a request: hold ready low for 'hold' cycles (optionally
    // with a stray response), then accept. Fields must stay put throughout.
    task automatic mem_req(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d,
                           input int hold, input bit stray);
        for (int k = 0; k <= hold; k++) begin
            mem_req_ready  = (k == hold);
            mem_resp_valid = stray && (k != hold);
            chk("req_valid", LW'(mem_req_valid), LW'(1'b1));
            chk("req_write", LW'(mem_req_write), LW'(wr));
            chk("req_addr", LW'(mem_req_addr), LW'(a));
            if (wr) chk("req_wdata", mem_req_wdata, d);
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        chk("req_dropped", LW'(mem_req_valid), LW'(1'b0));
    endtask

    // Response arrives 'lat' cycles after the first possible cycle
    task automatic mem_resp(input int lat, input logic [LW-1:0] d);
        for (int k = 0; k < lat; k++) begin
            chk("wait_busy", LW'(busy), LW'(1'b1));
            chk("wait_nofill", LW'(fill_en), LW'(1'b0));
            chk("wait_noreq", LW'(mem_req_valid), LW'(1'b0));
            mem_req_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = d;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = rand_line();
    endtask

    task automatic run_miss(input logic [3:0] vw, input logic [3:0] dw, input logic [3:0] rw,
                            input logic [AW-1:0] ma, input int hold_wb, input int hold_rd,
                            input int lat_wb, input int lat_rd, input bit stray);
        int            idx;
        logic [3:0]    ew;
        bit            wb;
        logic [LW-1:0] rd;
        logic [AW-1:0] wb_a;
        logic [LW-1:0] wb_d;
        idx  = way_index(rw);
        ew   = '0;
        ew[idx] = 1'b1;
        wb   = |(vw & dw & ew);
        wb_a = arr_addr[idx];
        wb_d = arr_data[idx];
        rd   = rand_line();

        chk("miss_ready_idle", LW'(miss_ready), LW'(1'b1));
        miss_valid = 1'b1;
        miss_addr  = ma;
        valid_ways = vw;
        dirty_ways = dw;
        repl_way   = rw;
        @(negedge clk);
        miss_valid = 1'b0;
        miss_addr  = $urandom;
        valid_ways = 4'($urandom);
        dirty_ways = 4'($urandom);
        repl_way   = 4'($urandom);
        exp_miss++;
        chk("victim_way", LW'(victim_way), LW'(ew));
        chk("busy_after_accept", LW'(busy), LW'(1'b1));
        chk("miss_ready_busy", LW'(miss_ready), LW'(1'b0));
        check_counters();

        if (wb) begin
            mem_req(1'b1, wb_a, wb_d, hold_wb, stray);
            mem_resp(lat_wb, rand_line());
            exp_wb++;
            chk("wb_cnt_after_ack", LW'(wb_cnt), LW'(sat(exp_wb, 65535)));
            chk("sat_wb_cnt_after_ack", LW'(s_wb_cnt), LW'(sat(exp_wb, 3)));
        end

        mem_req(1'b0, ma, '0, hold_rd, stray);
        mem_resp(lat_rd, rd);
        chk("fill_en", LW'(fill_en), LW'(1'b1));
        chk("done", LW'(done), LW'(1'b1));
        chk("fill_way", LW'(fill_way), LW'(ew));
        chk("fill_addr", LW'(fill_addr), LW'(ma));
        chk("fill_data", fill_data, rd);
        chk("fill_noreq", LW'(mem_req_valid), LW'(1'b0));
        @(negedge clk);
        chk("fill_pulse_end", LW'(fill_en), LW'(1'b0));
        chk("done_pulse_end", LW'(done), LW'(1'b0));
        chk("busy_end", LW'(busy), LW'(1'b0));
        check_counters();
    endtask

    initial begin
        fill_arrays();
        mem_resp_data = rand_line();

        // Reset state
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_miss_ready", LW'(miss_ready), LW'(1'b1));
        chk("rst_busy", LW'(busy), LW'(1'b0));
        chk("rst_req_valid", LW'(mem_req_valid), LW'(1'b0));
        chk("rst_fill_en", LW'(fill_en), LW'(1'b0));
        chk("rst_done", LW'(done), LW'(1'b0));
        chk("rst_victim_way", LW'(victim_way), LW'(4'b0));
        chk("rst_fill_data", fill_data, '0);
        check_counters();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Clean miss with immediate ready and response
        fill_arrays();
        run_miss(4'b0111, 4'b0000, 4'b1000, 32'h0000_1230, 0, 0, 0, 0, 1'b0);

        // Dirty victim written back to 0x40
        fill_arrays();
        arr_addr[2] = 32'h0000_0040;
        run_miss(4'b1111, 4'b0100, 4'b0100, 32'h0000_5670, 0, 0, 0, 1, 1'b0);

        // Backpressure in both request states with stray responses
        fill_arrays();
        run_miss(4'b1111, 4'b0100, 4'b0100, 32'h0000_9ab0, 5, 5, 2, 2, 1'b1);

        // Invalid replacement vectors
        fill_arrays();
        run_miss(4'b1111, 4'b1111, 4'b0000, 32'h0000_0100, 0, 0, 0, 0, 1'b0);
        fill_arrays();
        run_miss(4'b1111, 4'b0000, 4'b0110, 32'h0000_0200, 1, 1, 1, 1, 1'b0);

        // Randomized misses
        for (int n = 0; n < 30; n++) begin
            fill_arrays();
            run_miss(4'($urandom), 4'($urandom), 4'($urandom), $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for read data
        fill_arrays();
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_7770;
        valid_ways = 4'b0001;
        dirty_ways = 4'b0000;
        repl_way   = 4'b0001;
        @(negedge clk);
        miss_valid    = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("pre_reset_busy", LW'(busy), LW'(1'b1));
        rst = 1'b0;
        #1;
        exp_miss = 0;
        exp_wb   = 0;
        chk("async_busy", LW'(busy), LW'(1'b0));
        chk("async_miss_ready", LW'(miss_ready), LW'(1'b1));
        chk("async_req_valid", LW'(mem_req_valid), LW'(1'b0));
        check_counters();
        @(negedge clk);
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("late_resp_fill", LW'(fill_en), LW'(1'b0));
        chk("late_resp_done", LW'(done), LW'(1'b0));
        chk("late_resp_busy", LW'(busy), LW'(1'b0));
        @(negedge clk);
        chk("late_resp_fill2", LW'(fill_en), LW'(1'b0));

        // Counting restarts from zero after reset
        fill_arrays();
        run_miss(4'b1111, 4'b1000, 4'b1000, 32'h0000_abc0, 0, 2, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
